// File: rtl/display_value_scheduler_if.sv
// Sample-in / display-out bundle for the seven-segment value scheduler.
//
// Handshake: there is no back-pressure. sample_valid is a one-cycle strobe
// that the scheduler always accepts (there is no ready). sample is
// meaningful only while sample_valid is high. digits/blank are held levels
// that change only when a conversion commits. busy is high while a
// conversion is in flight.
interface display_value_scheduler_if #(
  parameter int WIDTH = 10
);
  logic signed [WIDTH-1:0] sample;
  logic                    sample_valid;
  logic [15:0]             digits;
  logic [3:0]              blank;
  logic                    busy;

  // Producer side: the accelerometer path drives samples and may observe the display.
  modport master (
    output sample,
    output sample_valid,
    input  digits,
    input  blank,
    input  busy
  );

  // Scheduler side.
  modport slave (
    input  sample,
    input  sample_valid,
    output digits,
    output blank,
    output busy
  );
endinterface

// File: rtl/display_value_scheduler.sv
// Rate-limited signed-sample to BCD converter for a four-digit readout.
//
// Incoming samples land in a hold register (latest strobe wins). On each
// update tick, if a fresh sample is waiting, it is captured, converted by
// serial double-dabble (one shift per clock), and committed to the digit
// and blank outputs in a single cycle. Digit 3 carries the sign code
// (4'hA renders a dash), digits 2..0 carry hundreds/tens/ones.
module display_value_scheduler #(
  parameter int WIDTH      = 10,
  parameter int UPDATE_DIV = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  display_value_scheduler_if.slave      bus,
  output logic [1:0]                    state_o
);

  localparam int             CW         = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST  = CW'(UPDATE_DIV - 1);
  localparam logic [3:0]     SHIFT_LAST = 4'(WIDTH - 1);
  localparam logic [3:0]     SIGN_NEG   = 4'hA;
  localparam logic [3:0]     SIGN_POS   = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  state_q,  state_d;
  logic [CW-1:0]           cnt_q,    cnt_d;
  logic signed [WIDTH-1:0] hold_q,   hold_d;
  logic                    fresh_q,  fresh_d;
  logic                    sign_q,   sign_d;
  logic [WIDTH-1:0]        mag_q,    mag_d;
  logic [11:0]             bcd_q,    bcd_d;
  logic [3:0]              sh_q,     sh_d;
  logic [15:0]             digits_q, digits_d;
  logic [3:0]              blank_q,  blank_d;
  logic                    busy_q,   busy_d;

  logic                    tick;
  logic                    capture;
  logic [WIDTH:0]          hold_ext;
  logic [11:0]             bcd_adj;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the doubling shift, so add 3 beforehand.
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  assign tick     = (cnt_q == TICK_LAST);
  assign capture  = (state_q == S_IDLE) && tick && fresh_q;
  // Sign-extend by one bit so negating the most negative value cannot overflow.
  assign hold_ext = {hold_q[WIDTH-1], hold_q};
  assign bcd_adj  = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

  // Next-state and datapath: defaults hold every register, then the FSM overrides.
  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : (cnt_q + CW'(1));
    hold_d   = hold_q;
    fresh_d  = fresh_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    sh_d     = sh_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    busy_d   = busy_q;

    // A capture consumes the pending sample, but a strobe on the same edge
    // re-arms fresh so the newer value shows on the following tick.
    if (capture) begin
      fresh_d = 1'b0;
    end
    if (bus.sample_valid) begin
      hold_d  = bus.sample;
      fresh_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_SHIFT;
          sign_d  = hold_q[WIDTH-1];
          // |x| <= 2^(WIDTH-1) < 2^WIDTH, so the top bit of the extended
          // magnitude is always zero and the low WIDTH bits are exact.
          mag_d   = WIDTH'(hold_q[WIDTH-1] ? -hold_ext : hold_ext);
          bcd_d   = '0;
          sh_d    = '0;
          busy_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        // Shift the corrected BCD accumulator and the magnitude as one word,
        // MSB of the magnitude entering the ones nibble.
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        sh_d           = sh_q + 4'd1;
        if (sh_q == SHIFT_LAST) begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        digits_d = {(sign_q ? SIGN_NEG : SIGN_POS), bcd_q};
        blank_d  = {~sign_q,
                    (bcd_q[11:8] == 4'd0),
                    (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0),
                    1'b0};
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register: synchronous reset aborts any conversion and shows "0".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      fresh_q  <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      bcd_q    <= '0;
      sh_q     <= '0;
      digits_q <= 16'h0000;
      blank_q  <= 4'b1110;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      fresh_q  <= fresh_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      sh_q     <= sh_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.blank  = blank_q;
  assign bus.busy   = busy_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_display_value_scheduler.sv
// Bench for display_value_scheduler with WIDTH=10, UPDATE_DIV=16.
module tb_display_value_scheduler;

  localparam int W   = 10;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_o;

  display_value_scheduler_if #(.WIDTH(W)) bus();

  display_value_scheduler #(.WIDTH(W), .UPDATE_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];   // {digits, blank}
  int n_checks = 0;
  int n_fail   = 0;
  int n_conv   = 0;
  int commit_prev = -1;
  int commit_last = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: decimal arithmetic on the integer value.
  function automatic logic [19:0] exp_for(input int v);
    int mag, h, t, o;
    logic [15:0] d;
    logic [3:0]  b;
    mag = (v < 0) ? -v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    d = {((v < 0) ? 4'hA : 4'h0), 4'(h), 4'(t), 4'(o)};
    b = {(v >= 0), (h == 0), (h == 0 && t == 0), 1'b0};
    return {d, b};
  endfunction

  // Monitor: a busy falling edge outside reset is a commit; compare against queue head.
  logic prev_busy = 1'b0;
  int   busy_len  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (bus.busy) busy_len++;
      if (prev_busy && !bus.busy) begin
        logic [19:0] e;
        n_conv++;
        commit_prev = commit_last;
        commit_last = cycle;
        check("busy_len", 32'(busy_len), 32'd11);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: digits=0x%0h blank=%b, no commit expected", bus.digits, bus.blank);
        end else begin
          e = exp_q.pop_front();
          check("digits", 32'(bus.digits), 32'(e[19:4]));
          check("blank",  32'(bus.blank),  32'(e[3:0]));
        end
        busy_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input int v, input bit push);
    bus.sample       = W'(v);
    bus.sample_valid = 1'b1;
    if (push) exp_q.push_back(exp_for(v));
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic strobe_exp(input int v, input logic [15:0] d, input logic [3:0] b);
    bus.sample       = W'(v);
    bus.sample_valid = 1'b1;
    exp_q.push_back({d, b});
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("wait_commit_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_busy();
    int i;
    for (i = 0; i < 100 && !bus.busy; i++) @(negedge clk);
    if (!bus.busy) check("wait_busy_timeout", 32'(bus.busy), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int          sample;
    logic [15:0] digits;
    logic [3:0]  blank;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int conv_before;
    vecs[0] = '{-512, 16'hA512, 4'b0000};
    vecs[1] = '{   7, 16'h0007, 4'b1110};
    vecs[2] = '{  -7, 16'hA007, 4'b0110};
    vecs[3] = '{ 511, 16'h0511, 4'b1000};
    vecs[4] = '{   0, 16'h0000, 4'b1110};
    vecs[5] = '{ -58, 16'hA058, 4'b0100};

    rst_n            = 1'b0;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digits", 32'(bus.digits), 32'h0000);
    check("reset_blank",  32'(bus.blank),  32'hE);
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_state",  32'(state_o),    32'd0);
    rst_n = 1'b1;

    // No strobe yet: ticks must not start a conversion.
    repeat (40) @(negedge clk);
    check("no_fresh_no_conv", 32'(n_conv), 32'd0);

    // Table of spec values.
    for (int i = 0; i < 6; i++) begin
      strobe_exp(vecs[i].sample, vecs[i].digits, vecs[i].blank);
      wait_idle();
    end

    // Random signed samples over the full range.
    for (int i = 0; i < 6; i++) begin
      strobe($urandom_range(0, 1023) - 512, 1'b1);
      wait_idle();
    end

    // Two strobes in one tick period: only the later one is converted.
    conv_before = n_conv;
    strobe(100, 1'b0);
    strobe(250, 1'b1);
    wait_idle();
    repeat (40) @(negedge clk);
    check("latest_wins_conv_count", 32'(n_conv - conv_before), 32'd1);
    check("latest_wins_digits", 32'(bus.digits), 32'h0250);

    // Strobe during SHIFT: in-flight value commits first, new one a tick later.
    strobe(300, 1'b1);
    wait_busy();
    repeat (3) @(negedge clk);
    strobe(42, 1'b1);
    wait_idle();
    check("mid_shift_commit_gap", 32'(commit_last - commit_prev), 32'(DIV));

    // Outputs hold across ticks with nothing fresh.
    conv_before = n_conv;
    repeat (40) @(negedge clk);
    check("hold_no_conv", 32'(n_conv - conv_before), 32'd0);
    check("hold_digits", 32'(bus.digits), 32'h0042);
    check("hold_blank",  32'(bus.blank),  32'hC);

    // Reset mid-SHIFT aborts the conversion and clears fresh.
    strobe(123, 1'b1);
    wait_busy();
    repeat (3) @(negedge clk);
    check("pre_reset_state_shift", 32'(state_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("midrst_digits", 32'(bus.digits), 32'h0000);
    check("midrst_blank",  32'(bus.blank),  32'hE);
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_state",  32'(state_o),    32'd0);
    rst_n = 1'b1;
    conv_before = n_conv;
    repeat (60) @(negedge clk);
    check("post_reset_no_conv", 32'(n_conv - conv_before), 32'd0);
    check("post_reset_digits",  32'(bus.digits), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_value_scheduler.md
# display_value_scheduler

Sequential front end for the four-digit seven-segment readout of the accelerometer axis value. It rate-limits incoming signed samples to a human-readable update rate and converts magnitude to BCD by serial double-dabble, one shift per clock. It then commits sign, hundreds, tens and ones codes, plus per-digit blank flags, to the four `DisplayNumber` decoder instances in a single cycle. Sits between the accelerometer sample path and the decoders; the top level forces a digit's segments to 7'h7F when its blank flag is set.

## Interface
- `WIDTH`, 10: sample width, two's complement; legal range 2..10, so the magnitude is at most 512 and fits in three BCD digits.
- `UPDATE_DIV`, 5_000_000: clock cycles per display update tick (10 Hz at 50 MHz); must be at least WIDTH+3.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `sample`  input  WIDTH  signed axis value.
- `sample_valid`  input  1  one-cycle strobe; `sample` is captured into the hold register.
- `digits`  output  16  decoder codes: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] sign.
- `blank`  output  4  per-digit blank, active-high; bit0 ones, bit1 tens, bit2 hundreds, bit3 sign.
- `busy`  output  1  conversion in progress.

## Operation
- **Hold register.** On `sample_valid`, store `sample` and set the `fresh` flag. The latest strobe wins, and strobes are accepted in any state.
- **Tick counter.** Counts 0..UPDATE_DIV-1, wraps, and runs freely. `tick` is high when the count equals UPDATE_DIV-1.
- **State machine: IDLE, SHIFT, COMMIT.**
  - IDLE → SHIFT on an edge with `tick && fresh`.
    - Capture sign = hold[WIDTH-1].
    - Capture magnitude = |hold|, computed in WIDTH+1 bits so that -2^(WIDTH-1) converts correctly.
    - Clear the 12-bit BCD accumulator and the shift counter; clear `fresh`; `busy` goes to 1.
  - SHIFT: on each edge, every BCD nibble ≥5 gets +3, then {BCD, magnitude} shifts left by one. After WIDTH shifts → COMMIT.
  - COMMIT → IDLE.
    - Load `digits` from the BCD nibbles.
    - Sign code is 4'hA if negative (the decoder default renders a dash), else 4'h0.
    - Load `blank` and clear `busy`.
- **Blank rules.**
  - Sign is blank iff the value is non-negative.
  - Hundreds is blank iff hundreds = 0.
  - Tens is blank iff hundreds = 0 and tens = 0.
  - Ones is never blank.
- **Boundary behaviour.**
  - A tick with `fresh` = 0 does nothing, and the outputs hold.
  - A tick while `busy` is ignored; the capture waits for the next tick.
  - `sample_valid` on the capture edge: the capture uses the pre-edge hold value. The new sample is written and `fresh` stays set, so it displays on the next tick.
  - `sample_valid` during SHIFT/COMMIT updates only the hold register; the conversion in flight is unaffected.
- **Output stability.** `digits` and `blank` change only on the COMMIT edge or on reset, so there are no partial values.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-conversion:
  - Abort; state returns to IDLE.
  - `digits` = 16'h0000, `blank` = 4'b1110 (shows "0"), `busy` = 0.
  - Tick counter = 0, `fresh` = 0, hold register = 0.
- Capture edge E0. Shift edges E1..E(WIDTH). Commit edge E(WIDTH+1).
- New outputs are visible after E(WIDTH+1): 11 cycles after capture for WIDTH=10.
- `busy` is high from after E0 through E(WIDTH+1), exclusive.
- Sample-to-display latency is at most UPDATE_DIV + WIDTH + 1 cycles.
- The first tick after reset comes UPDATE_DIV cycles after reset release.

## Test plan
All scenarios use UPDATE_DIV=16 and WIDTH=10.
- Reset mid-SHIFT → next cycle `digits`=16'h0000, `blank`=4'b1110, `busy`=0; with no further strobes, there is no conversion on later ticks.
- sample=-512, strobe → at commit, `digits`=16'hA512, `blank`=4'b0000; `busy` high for exactly 11 cycles.
- sample=7 → `digits`=16'h0007, `blank`=4'b1110; sample=-7 → `digits`=16'hA007, `blank`=4'b0110.
- sample=511 → `digits`=16'h0511, `blank`=4'b1000; sample=0 → `digits`=16'h0000, `blank`=4'b1110.
- Strobes of 100 then 250 within one tick period → only 250 is displayed (16'h0250, `blank`=4'b1000), with exactly one conversion.
- Strobe of 42 during SHIFT of 300 → 300 commits first; 42 commits after the following tick.
